// File: rtl/axi_ooo_read_slave.sv
// Out-of-order AR/R read slave: holds up to DEPTH single-beat requests, each
// released after an LFSR-chosen delay; rdata carries the acceptance sequence number.
module axi_ooo_read_slave #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ID_WIDTH   = 4,
  parameter int          DEPTH      = 8,
  parameter int          DELAY_W    = 3,
  parameter int          MIN_DELAY  = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  input  logic                  s_rready_i,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o
);

  localparam int CNT_W = $clog2(MIN_DELAY + 2**DELAY_W);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]      ent_valid;
  logic [ID_WIDTH-1:0]   ent_id  [DEPTH];
  logic [DATA_WIDTH-1:0] ent_seq [DEPTH];
  logic [CNT_W-1:0]      ent_cnt [DEPTH];

  logic [DATA_WIDTH-1:0] seq;
  logic [15:0]           lfsr;
  logic [15:0]           lfsr_next;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      rr_next;

  logic                  full;
  logic                  id_busy;
  logic                  ar_hs;
  logic [IDX_W-1:0]      alloc_idx;
  logic [DEPTH-1:0]      elig;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      cand;
  logic                  loadable;
  logic                  issue;
  logic [CNT_W-1:0]      new_cnt;

  assign full        = &ent_valid;
  assign s_arready_o = !full && !id_busy;
  assign ar_hs       = s_arvalid_i && s_arready_o;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign new_cnt   = CNT_W'(MIN_DELAY) + CNT_W'(lfsr[DELAY_W-1:0]);

  always_comb begin
    id_busy = s_rvalid_o && (s_rid_o == s_arid_i);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_id[i] == s_arid_i)) id_busy = 1'b1;
    end
  end

  // Scan downward so the last write wins with the lowest free index
  always_comb begin
    alloc_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!ent_valid[DEPTH-1-k]) alloc_idx = IDX_W'(DEPTH - 1 - k);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      elig[i] = ent_valid[i] && (ent_cnt[i] == '0);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % DEPTH);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign loadable = !s_rvalid_o || s_rready_i;
  assign issue    = loadable && sel_found;
  assign rr_next  = (sel_idx == IDX_W'(DEPTH - 1)) ? '0 : sel_idx + IDX_W'(1);

  // Allocated and issued indices are always distinct: one was free, the other valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_id[i]  <= '0;
        ent_seq[i] <= '0;
        ent_cnt[i] <= '0;
      end
      seq    <= '0;
      lfsr   <= LFSR_SEED;
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (ent_cnt[i] != '0)) ent_cnt[i] <= ent_cnt[i] - 1'b1;
        if (issue && (sel_idx == IDX_W'(i))) ent_valid[i] <= 1'b0;
        if (ar_hs && (alloc_idx == IDX_W'(i))) begin
          ent_valid[i] <= 1'b1;
          ent_id[i]    <= s_arid_i;
          ent_seq[i]   <= seq;
          ent_cnt[i]   <= new_cnt;
        end
      end
      if (ar_hs) begin
        seq  <= seq + 1'b1;
        lfsr <= lfsr_next;
      end
      if (issue) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid_o <= 1'b0;
      s_rid_o    <= '0;
      s_rdata_o  <= '0;
    end else if (issue) begin
      s_rvalid_o <= 1'b1;
      s_rid_o    <= ent_id[sel_idx];
      s_rdata_o  <= ent_seq[sel_idx];
    end else if (s_rvalid_o && s_rready_i) begin
      s_rvalid_o <= 1'b0;
    end
  end

endmodule
